epb_master: RTL

Wishbone-slave-to-EPB initiator for the ROACH CPLD register map. It converts one 8-bit Wishbone access into a PPC-style External Peripheral Bus cycle with programmable setup, strobe and hold phases. It is the initiator-side counterpart of the EPB-to-Wishbone bridge and drives that bridge from FPGA test logic or a bench host. One transfer is in flight at a time, and bursts are not supported.

---
 rtl/epb_pkg.sv | 23 ++
 rtl/epb_master_if.sv | 48 ++++
 rtl/epb_phase_counter.sv | 28 ++
 rtl/epb_master.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/epb_pkg.sv
// Shared definitions for the Wishbone-to-EPB initiator: FSM state encoding,
// phase/timeout counter widths and the phase-length load helper.
package epb_pkg;

    localparam int PHASE_W = 4;
    localparam int TMO_W   = 8;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETUP  = 3'd1,
        ST_STROBE = 3'd2,
        ST_HOLD   = 3'd3,
        ST_ACK    = 3'd4
    } state_t;

    typedef logic [PHASE_W-1:0] phase_t;

    // Down-counter reload value: a phase of N cycles ends when the count hits 0.
    function automatic phase_t phase_load(input int cycles);
        return phase_t'(cycles - 1);
    endfunction

endpackage

// File: rtl/epb_master_if.sv
// Wishbone slave + EPB initiator signal bundle. epb_rdy/epb_timeout exist only
// when EPB_MASTER_RDY_EN is defined.
interface epb_master_if;

    logic       wb_cyc_i;
    logic       wb_stb_i;
    logic       wb_we_i;
    logic [4:0] wb_adr_i;
    logic [7:0] wb_dat_i;
    logic [7:0] wb_dat_o;
    logic       wb_ack_o;

    logic       epb_cs_n;
    logic       epb_we_n;
    logic       epb_oen_n;
    logic       epb_be_n;
    logic [4:0] epb_addr;
    logic [7:0] epb_data_o;
    logic       epb_data_oe;
    logic [7:0] epb_data_i;
`ifdef EPB_MASTER_RDY_EN
    logic       epb_rdy;
    logic       epb_timeout;
`endif

    // Bridge side: accepts Wishbone accesses and initiates EPB cycles.
    modport master (
`ifdef EPB_MASTER_RDY_EN
        input  epb_rdy,
        output epb_timeout,
`endif
        input  wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_dat_i, epb_data_i,
        output wb_dat_o, wb_ack_o, epb_cs_n, epb_we_n, epb_oen_n, epb_be_n,
        output epb_addr, epb_data_o, epb_data_oe
    );

    // Environment side: Wishbone host plus EPB target.
    modport slave (
`ifdef EPB_MASTER_RDY_EN
        output epb_rdy,
        input  epb_timeout,
`endif
        output wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_dat_i, epb_data_i,
        input  wb_dat_o, wb_ack_o, epb_cs_n, epb_we_n, epb_oen_n, epb_be_n,
        input  epb_addr, epb_data_o, epb_data_oe
    );

endinterface

// File: rtl/epb_phase_counter.sv
// Shared phase down-counter: load has priority, decrement saturates at zero so
// the zero flag stays up while the FSM lingers in a phase.
module epb_phase_counter
    import epb_pkg::*;
(
    input  logic   clk,
    input  logic   reset_n,
    input  logic   load,
    input  phase_t load_val,
    input  logic   dec,
    output logic   zero
);

    phase_t cnt_reg;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_reg <= '0;
        end else if (load) begin
            cnt_reg <= load_val;
        end else if (dec && (cnt_reg != '0)) begin
            cnt_reg <= cnt_reg - 1'b1;
        end
    end

    assign zero = (cnt_reg == '0);

endmodule

// File: rtl/epb_master.sv
// Wishbone-to-EPB initiator: one 8-bit access becomes a SETUP/STROBE/HOLD EPB
// cycle. Define EPB_MASTER_RDY_EN to extend STROBE on epb_rdy with a timeout.
module epb_master
    import epb_pkg::*;
#(
    parameter int SETUP_CYCLES   = 2,
    parameter int STROBE_CYCLES  = 4,
    parameter int HOLD_CYCLES    = 1,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic         clk,
    input  logic         reset_n,
    epb_master_if.master bus
);

    if (SETUP_CYCLES < 1 || SETUP_CYCLES > 15 || STROBE_CYCLES < 1 || STROBE_CYCLES > 15 ||
        HOLD_CYCLES < 1 || HOLD_CYCLES > 15 || TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_cfg
        $error("epb_master: phase or timeout length out of range");
    end

    localparam phase_t SETUP_LOAD  = phase_load(SETUP_CYCLES);
    localparam phase_t STROBE_LOAD = phase_load(STROBE_CYCLES);
    localparam phase_t HOLD_LOAD   = phase_load(HOLD_CYCLES);

    state_t     state_reg, state_next;
    logic [4:0] addr_reg, addr_next;
    logic [7:0] wdat_reg, wdat_next;
    logic [7:0] rdat_reg, rdat_next;
    logic       we_reg, we_next;
    logic       alive_reg, alive_next;
    logic       cs_n_reg, cs_n_next;
    logic       we_n_reg, we_n_next;
    logic       oen_n_reg, oen_n_next;
    logic       be_n_reg, be_n_next;
    logic       oe_reg, oe_next;
    logic       ack_reg, ack_next;

    logic       ph_load, ph_dec, ph_zero;
    phase_t     ph_load_val;
    logic       strobe_done, strobe_expired;

    epb_phase_counter u_phase (
        .clk      (clk),
        .reset_n  (reset_n),
        .load     (ph_load),
        .load_val (ph_load_val),
        .dec      (ph_dec),
        .zero     (ph_zero)
    );

`ifdef EPB_MASTER_RDY_EN
    localparam logic [TMO_W-1:0] TMO_LIMIT = TMO_W'(TIMEOUT_CYCLES);

    logic [TMO_W-1:0] tmo_cnt_reg, tmo_cnt_next;
    logic             timeout_reg, timeout_next;

    // tmo_cnt counts STROBE cycles starting at 1; a late rdy on the limit edge still wins.
    assign strobe_done    = (ph_zero && bus.epb_rdy) || (tmo_cnt_reg == TMO_LIMIT);
    assign strobe_expired = (tmo_cnt_reg == TMO_LIMIT) && !(ph_zero && bus.epb_rdy);
    assign bus.epb_timeout = timeout_reg;
`else
    assign strobe_done    = ph_zero;
    assign strobe_expired = 1'b0;
`endif

    always_comb begin
        state_next  = state_reg;
        addr_next   = addr_reg;
        wdat_next   = wdat_reg;
        rdat_next   = rdat_reg;
        we_next     = we_reg;
        alive_next  = alive_reg;
        cs_n_next   = cs_n_reg;
        we_n_next   = we_n_reg;
        oen_n_next  = oen_n_reg;
        be_n_next   = be_n_reg;
        oe_next     = oe_reg;
        ack_next    = 1'b0;
        ph_load     = 1'b0;
        ph_load_val = '0;
        ph_dec      = 1'b0;
`ifdef EPB_MASTER_RDY_EN
        tmo_cnt_next = tmo_cnt_reg;
        timeout_next = timeout_reg;
`endif
        // An abort anywhere in the EPB cycle only suppresses the ack.
        if (state_reg == ST_SETUP || state_reg == ST_STROBE || state_reg == ST_HOLD) begin
            alive_next = alive_reg && bus.wb_cyc_i;
        end

        case (state_reg)
            ST_IDLE: begin
                if (bus.wb_cyc_i && bus.wb_stb_i && !ack_reg) begin
                    state_next  = ST_SETUP;
                    addr_next   = bus.wb_adr_i;
                    we_next     = bus.wb_we_i;
                    alive_next  = 1'b1;
                    cs_n_next   = 1'b0;
                    ph_load     = 1'b1;
                    ph_load_val = SETUP_LOAD;
                    if (bus.wb_we_i) begin
                        oe_next   = 1'b1;
                        wdat_next = bus.wb_dat_i;
                    end
                end
            end
            ST_SETUP: begin
                ph_dec = 1'b1;
                if (ph_zero) begin
                    state_next  = ST_STROBE;
                    be_n_next   = 1'b0;
                    we_n_next   = !we_reg;
                    oen_n_next  = we_reg;
                    ph_load     = 1'b1;
                    ph_load_val = STROBE_LOAD;
`ifdef EPB_MASTER_RDY_EN
                    tmo_cnt_next = TMO_W'(1);
`endif
                end
            end
            ST_STROBE: begin
                ph_dec = 1'b1;
`ifdef EPB_MASTER_RDY_EN
                tmo_cnt_next = tmo_cnt_reg + 1'b1;
                if (strobe_expired) begin
                    timeout_next = 1'b1;
                end
`endif
                if (strobe_done) begin
                    state_next  = ST_HOLD;
                    we_n_next   = 1'b1;
                    oen_n_next  = 1'b1;
                    be_n_next   = 1'b1;
                    ph_load     = 1'b1;
                    ph_load_val = HOLD_LOAD;
                    if (!we_reg) begin
                        rdat_next = strobe_expired ? 8'hFF : bus.epb_data_i;
                    end
                end
            end
            ST_HOLD: begin
                ph_dec = 1'b1;
                if (ph_zero) begin
                    state_next = ST_ACK;
                    cs_n_next  = 1'b1;
                    oe_next    = 1'b0;
                    ack_next   = alive_reg && bus.wb_cyc_i;
                end
            end
            ST_ACK: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= ST_IDLE;
            addr_reg  <= '0;
            wdat_reg  <= '0;
            rdat_reg  <= '0;
            we_reg    <= 1'b0;
            alive_reg <= 1'b0;
            cs_n_reg  <= 1'b1;
            we_n_reg  <= 1'b1;
            oen_n_reg <= 1'b1;
            be_n_reg  <= 1'b1;
            oe_reg    <= 1'b0;
            ack_reg   <= 1'b0;
`ifdef EPB_MASTER_RDY_EN
            tmo_cnt_reg <= '0;
            timeout_reg <= 1'b0;
`endif
        end else begin
            state_reg <= state_next;
            addr_reg  <= addr_next;
            wdat_reg  <= wdat_next;
            rdat_reg  <= rdat_next;
            we_reg    <= we_next;
            alive_reg <= alive_next;
            cs_n_reg  <= cs_n_next;
            we_n_reg  <= we_n_next;
            oen_n_reg <= oen_n_next;
            be_n_reg  <= be_n_next;
            oe_reg    <= oe_next;
            ack_reg   <= ack_next;
`ifdef EPB_MASTER_RDY_EN
            tmo_cnt_reg <= tmo_cnt_next;
            timeout_reg <= timeout_next;
`endif
        end
    end

    assign bus.wb_dat_o    = rdat_reg;
    assign bus.wb_ack_o    = ack_reg;
    assign bus.epb_cs_n    = cs_n_reg;
    assign bus.epb_we_n    = we_n_reg;
    assign bus.epb_oen_n   = oen_n_reg;
    assign bus.epb_be_n    = be_n_reg;
    assign bus.epb_addr    = addr_reg;
    assign bus.epb_data_o  = wdat_reg;
    assign bus.epb_data_oe = oe_reg;

endmodule
